ifmap_tag_gen: RTL and testbench

//  Upstream feeder of the GIN. Reads an ifmap tile from the global buffer (1-cycle sync-read SRAM).

---
 rtl/ifmap_tag_gen.sv | 136 +++++++++++++
 tb/tb_ifmap_tag_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_tag_gen.sv
// ifmap_tag_gen: scans an ifmap tile out of the global buffer in column-major
// order, tags each element with (row_tag, col_tag) and offers it to the GIN
// over an enable/ready handshake. One element is in flight at a time:
// RD issues the read, CAP registers the returned data, SEND holds it until
// it is accepted.
module ifmap_tag_gen #(
  parameter int ID_LEN    = 5,
  parameter int ROW_LEN   = 4,
  parameter int VALUE_LEN = 8,
  parameter int ADDR_LEN  = 14,
  parameter int DIM_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_LEN-1:0]  base_addr,
  input  logic [DIM_LEN-1:0]   num_rows,
  input  logic [DIM_LEN-1:0]   num_cols,
  input  logic [ID_LEN-1:0]    tag_div,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_LEN-1:0]  rd_addr,
  input  logic [VALUE_LEN-1:0] rd_data,
  output logic                 enable,
  input  logic                 ready,
  output logic [ROW_LEN-1:0]   row_tag,
  output logic [ID_LEN-1:0]    col_tag,
  output logic [VALUE_LEN-1:0] value
);

  typedef enum logic [2:0] {IDLE, RD, CAP, SEND, DONE} state_t;

  state_t state, state_nxt;

  // Configuration latched at the accepting start
  logic [ADDR_LEN-1:0] base;
  logic [DIM_LEN-1:0]  nrows;
  logic [DIM_LEN-1:0]  ncols;
  logic [ID_LEN-1:0]   div;

  // Scan position
  logic [DIM_LEN-1:0]  r;
  logic [DIM_LEN-1:0]  c;
  logic [ADDR_LEN-1:0] addr;

  logic                empty_tile;
  logic                accept;
  logic                xfer;
  logic                last_row;
  logic                last_col;
  logic [DIM_LEN-1:0]  c_nxt;

  assign empty_tile = (num_rows == '0) || (num_cols == '0);
  assign accept     = (state == IDLE) && start && !empty_tile;
  assign xfer       = (state == SEND) && ready;
  assign last_row   = (r == nrows - DIM_LEN'(1));
  assign last_col   = (c == ncols - DIM_LEN'(1));
  assign c_nxt      = c + DIM_LEN'(1);

  // Handshake and status strobes are pure state decodes
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rd_en   = (state == RD);
  assign enable  = (state == SEND);
  assign rd_addr = addr;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; an empty tile goes straight to DONE without any read
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = empty_tile ? DONE : RD;
      RD:   state_nxt = CAP;
      CAP:  state_nxt = SEND;
      SEND: if (ready) state_nxt = (last_row && last_col) ? DONE : RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, index/tag/address advance and data capture.
  // Tags are tracked incrementally so no divider is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base    <= '0;
      nrows   <= '0;
      ncols   <= '0;
      div     <= '0;
      r       <= '0;
      c       <= '0;
      addr    <= '0;
      row_tag <= '0;
      col_tag <= '0;
      value   <= '0;
    end else begin
      if (accept) begin
        base    <= base_addr;
        nrows   <= num_rows;
        ncols   <= num_cols;
        div     <= (tag_div == '0) ? ID_LEN'(1) : tag_div;
        r       <= '0;
        c       <= '0;
        addr    <= base_addr;
        row_tag <= '0;
        col_tag <= '0;
      end
      if (state == CAP) value <= rd_data;
      if (xfer && !(last_row && last_col)) begin
        if (last_row) begin
          // Column finished: restart at row 0 of the next column
          r       <= '0;
          c       <= c_nxt;
          addr    <= base + ADDR_LEN'(c_nxt);
          row_tag <= '0;
          col_tag <= '0;
        end else begin
          r    <= r + DIM_LEN'(1);
          addr <= addr + ADDR_LEN'(ncols);
          if (col_tag == div - ID_LEN'(1)) begin
            col_tag <= '0;
            row_tag <= row_tag + ROW_LEN'(1);
          end else begin
            col_tag <= col_tag + ID_LEN'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ifmap_tag_gen.sv
// Directed bench for ifmap_tag_gen with a 1-cycle sync-read buffer model
// holding mem[i] = i & 8'hFF.
module tb_ifmap_tag_gen;

  localparam int ID_LEN    = 5;
  localparam int ROW_LEN   = 4;
  localparam int VALUE_LEN = 8;
  localparam int ADDR_LEN  = 14;
  localparam int DIM_LEN   = 8;
  localparam int MEM_SIZE  = 1 << ADDR_LEN;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [ADDR_LEN-1:0]  base_addr = '0;
  logic [DIM_LEN-1:0]   num_rows = '0;
  logic [DIM_LEN-1:0]   num_cols = '0;
  logic [ID_LEN-1:0]    tag_div = '0;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDR_LEN-1:0]  rd_addr;
  logic [VALUE_LEN-1:0] rd_data = '0;
  logic                 enable;
  logic                 ready = 1'b0;
  logic [ROW_LEN-1:0]   row_tag;
  logic [ID_LEN-1:0]    col_tag;
  logic [VALUE_LEN-1:0] value;

  int tests = 0;
  int fails = 0;

  logic [VALUE_LEN-1:0] mem [0:MEM_SIZE-1];

  ifmap_tag_gen #(
    .ID_LEN(ID_LEN), .ROW_LEN(ROW_LEN), .VALUE_LEN(VALUE_LEN),
    .ADDR_LEN(ADDR_LEN), .DIM_LEN(DIM_LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .num_cols(num_cols), .tag_div(tag_div),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .enable(enable), .ready(ready),
    .row_tag(row_tag), .col_tag(col_tag), .value(value)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Scan one tile and check every read address, every offered element,
  // hold stability under back-pressure and the done pulse.
  // spk >= 0: pulse a conflicting start once k reaches spk.
  // abort_k >= 0: pulse rst low once k transfers have completed.
  task automatic scan_tile(input int base, input int rows, input int cols,
                           input int div, input int duty, input int spk,
                           input int abort_k, input bit chk_timing);
    int total, k, cyc, budget, r, c, dv, ea;
    logic [VALUE_LEN-1:0] ev, hv;
    logic [ROW_LEN-1:0]   er, hr;
    logic [ID_LEN-1:0]    ec, hc;
    bit held, pulsed;
    total  = rows * cols;
    dv     = (div == 0) ? 1 : div;
    budget = total * 20 + 50;
    held   = 1'b0;
    pulsed = 1'b0;
    k      = 0;
    hv = '0; hr = '0; hc = '0;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_LEN'(base); num_rows = DIM_LEN'(rows);
    num_cols = DIM_LEN'(cols); tag_div = ID_LEN'(div); ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (k < total && cyc < budget) begin
      if (abort_k >= 0 && k == abort_k) begin
        rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, rd_en, enable, rd_addr, row_tag, col_tag, value} !== '0) begin
          fails++;
          $display("FAIL abort_zero: busy=%0b done=%0b rd_en=%0b en=%0b addr=%0h rt=%0d ct=%0d v=%0h, required all 0",
                   busy, done, rd_en, enable, rd_addr, row_tag, col_tag, value);
        end
        @(negedge clk);
        rst = 1'b1;
        ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          tests++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: done=%0b busy=%0b, required 0/0", done, busy);
          end
        end
        ready = 1'b0;
        return;
      end
      r  = k % rows;
      c  = k / rows;
      ea = (base + r * cols + c) % MEM_SIZE;
      ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      start = 1'b0;
      if (spk >= 0 && !pulsed && k >= spk) begin
        start = 1'b1; base_addr = 14'h1234; num_rows = 8'd3; num_cols = 8'd1;
        pulsed = 1'b1;
      end
      if (rd_en) begin
        tests++;
        if (rd_addr !== ADDR_LEN'(ea)) begin
          fails++;
          $display("FAIL rd_addr k=%0d: got %0h, required %0h", k, rd_addr, ea);
        end
      end
      if (enable) begin
        ev = VALUE_LEN'(ea);
        er = ROW_LEN'(r / dv);
        ec = ID_LEN'(r % dv);
        tests++;
        if (value !== ev || row_tag !== er || col_tag !== ec) begin
          fails++;
          $display("FAIL elem k=%0d: got v=%0h rt=%0d ct=%0d, required v=%0h rt=%0d ct=%0d",
                   k, value, row_tag, col_tag, ev, er, ec);
        end
        if (held) begin
          tests++;
          if (value !== hv || row_tag !== hr || col_tag !== hc) begin
            fails++;
            $display("FAIL hold k=%0d: got v=%0h rt=%0d ct=%0d, required v=%0h rt=%0d ct=%0d",
                     k, value, row_tag, col_tag, hv, hr, hc);
          end
        end
        if (ready) begin
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1; hv = value; hr = row_tag; hc = col_tag;
        end
      end else if (held) begin
        tests++;
        fails++;
        $display("FAIL enable_drop k=%0d: got enable=0, required 1", k);
        held = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    start = 1'b0;
    tests++;
    if (k < total) begin
      fails++;
      $display("FAIL timeout: got %0d transfers, required %0d", k, total);
      return;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || enable !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%0b busy=%0b en=%0b rd_en=%0b, required 1/1/0/0",
               done, busy, enable, rd_en);
    end
    if (chk_timing) begin
      tests++;
      if (cyc != 3 * total + 1) begin
        fails++;
        $display("FAIL latency: done at cycle %0d, required %0d", cyc, 3 * total + 1);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_single: done=%0b busy=%0b, required 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, done, rd_en, enable, rd_addr, row_tag, col_tag, value} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%0b done=%0b rd_en=%0b en=%0b addr=%0h rt=%0d ct=%0d v=%0h, required all 0",
               busy, done, rd_en, enable, rd_addr, row_tag, col_tag, value);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b, required 0/0", busy, done);
    end
  endtask

  task automatic test_empty(input int rows, input int cols);
    @(negedge clk);
    start = 1'b1; num_rows = DIM_LEN'(rows); num_cols = DIM_LEN'(cols);
    base_addr = 14'h0040; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || rd_en !== 1'b0 || enable !== 1'b0) begin
      fails++;
      $display("FAIL empty_%0dx%0d: done=%0b busy=%0b rd_en=%0b en=%0b, required 1/1/0/0",
               rows, cols, done, busy, rd_en, enable);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || enable !== 1'b0) begin
      fails++;
      $display("FAIL empty_end_%0dx%0d: done=%0b busy=%0b rd_en=%0b en=%0b, required 0/0/0/0",
               rows, cols, done, busy, rd_en, enable);
    end
    ready = 1'b0;
  endtask

  task automatic test_full_tile();
    scan_tile(0, 60, 224, 30, 100, -1, -1, 1'b1);
  endtask

  task automatic test_random_ready();
    scan_tile(0, 60, 20, 30, 30, -1, -1, 1'b0);
  endtask

  task automatic test_tag_groups();
    scan_tile(0, 60, 2, 14, 100, -1, -1, 1'b1);
    scan_tile(5, 20, 1, 1, 100, -1, -1, 1'b1);
    scan_tile(7, 3, 2, 0, 100, -1, -1, 1'b1);
  endtask

  task automatic test_addr_wrap();
    scan_tile(16380, 3, 4, 2, 100, -1, -1, 1'b1);
  endtask

  task automatic test_start_while_busy();
    scan_tile(100, 60, 4, 7, 100, 50, -1, 1'b1);
  endtask

  task automatic test_abort();
    scan_tile(0, 60, 224, 30, 100, -1, 100, 1'b0);
    scan_tile(16, 4, 3, 2, 100, -1, -1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = VALUE_LEN'(i);
    test_reset();
    test_empty(0, 5);
    test_empty(4, 0);
    test_full_tile();
    test_random_ready();
    test_tag_groups();
    test_addr_wrap();
    test_start_while_busy();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
